// File: rtl/switch_mcu_dummy_sram.sv
// Read-only AHB-Lite dummy SRAM: fixed-content ROM, 2^ADDR_W words of 32 bits.
// Latency: zero wait states for legal transfers; illegal ones get a two-cycle ERROR.
// Backpressure: out_hready drops only in the first ERROR cycle; no other stalls.
//
// Ports:
//   in_clk, in_rst (async, active-low)   clock and reset
//   in_haddr/in_hwrite/in_hsize/in_htrans AHB address phase (burst/prot/lock ignored)
//   out_hready/out_hresp/out_hrdata      AHB data-phase response
module switch_mcu_dummy_sram #(
  parameter int ADDR_W = 8
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [31:0] in_haddr,
  input  logic        in_hwrite,
  input  logic [3:0]  in_hsize,
  input  logic [2:0]  in_hburst,
  input  logic [3:0]  in_hport,
  input  logic [1:0]  in_htrans,
  input  logic        in_hmastlock,
  output logic        out_hready,
  output logic        out_hresp,
  output logic [31:0] out_hrdata
);

  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic {
    ST_OKAY = 1'b0,
    ST_ERR1 = 1'b1
  } state_t;

  state_t      state;
  logic        hresp_q;
  logic [31:0] hrdata_q;

  // Constant contents: word i = C0DE_00ii. Never written, so this folds to logic.
  logic [31:0] rom [2**ADDR_W];
  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_rom
    assign rom[i] = {16'hC0DE, 8'h00, 8'(i)};
  end

  logic              sample;
  logic              aligned;
  logic              in_range;
  logic              legal;
  logic [ADDR_W-1:0] word_idx;

  assign word_idx = in_haddr[ADDR_W+1:2];

  // An address phase is only accepted while we are driving hready high,
  // which is exactly the OKAY state (ERR1 is the only wait cycle).
  assign sample = (state == ST_OKAY) &&
                  ((in_htrans == HTRANS_NONSEQ) || (in_htrans == HTRANS_SEQ));

  always_comb begin
    aligned = 1'b0;
    case (in_hsize)
      4'd0:    aligned = 1'b1;
      4'd1:    aligned = ~in_haddr[0];
      4'd2:    aligned = (in_haddr[1:0] == 2'b00);
      default: aligned = 1'b0;  // sizes above a word are illegal
    endcase
  end

  // Every address bit above the word array must be zero.
  assign in_range = ((in_haddr >> (ADDR_W + 2)) == 32'd0);
  assign legal    = aligned && in_range;

  // Response FSM. hresp_q is set on entry to ERR1 and held one more cycle so
  // that the second ERROR cycle (hready=1, hresp=1) comes from OKAY state.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state    <= ST_OKAY;
      hresp_q  <= 1'b0;
      hrdata_q <= 32'h0;
    end else begin
      case (state)
        ST_OKAY: begin
          if (sample && !legal) begin
            state   <= ST_ERR1;
            hresp_q <= 1'b1;
          end else begin
            hresp_q <= 1'b0;
            // Reads always return the full word; writes are accepted and dropped.
            if (sample && !in_hwrite) begin
              hrdata_q <= rom[word_idx];
            end
          end
        end
        ST_ERR1: begin
          // Address phase presented now is ignored (hready is low).
          state   <= ST_OKAY;
          hresp_q <= 1'b1;
        end
        default: begin
          state   <= ST_OKAY;
          hresp_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_hready = (state == ST_OKAY);
  assign out_hresp  = hresp_q;
  assign out_hrdata = hrdata_q;

  // Burst type, protection and lock carry no meaning for a fixed ROM.
  logic unused_ahb_ctrl;
  assign unused_ahb_ctrl = ^{in_hburst, in_hport, in_hmastlock};

endmodule

// File: tb/tb_switch_mcu_dummy_sram.sv
// Self-checking bench for switch_mcu_dummy_sram: directed vectors plus random
// traffic; expected data-phase responses are queued at address-phase drive time
// and compared one cycle later.
module tb_switch_mcu_dummy_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr;
  logic        hwrite;
  logic [3:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hport;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  always #5 clk = ~clk;

  switch_mcu_dummy_sram #(.ADDR_W(8)) dut (
    .in_clk       (clk),
    .in_rst       (rst_n),
    .in_haddr     (haddr),
    .in_hwrite    (hwrite),
    .in_hsize     (hsize),
    .in_hburst    (hburst),
    .in_hport     (hport),
    .in_htrans    (htrans),
    .in_hmastlock (hmastlock),
    .out_hready   (hready),
    .out_hresp    (hresp),
    .out_hrdata   (hrdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        rdy;
    logic        resp;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];

  // Reference state: pending first ERROR cycle and last returned read data.
  bit          m_err1  = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    return 32'hC0DE_0000 | ((addr >> 2) & 32'h0000_00FF);
  endfunction

  function automatic bit exp_legal(input logic [31:0] addr, input logic [3:0] size);
    if (size > 4'd2)                          return 1'b0;
    if (size == 4'd1 && (addr % 2) != 0)      return 1'b0;
    if (size == 4'd2 && (addr % 4) != 0)      return 1'b0;
    if (addr >= 32'h0000_0400)                return 1'b0;
    return 1'b1;
  endfunction

  // One address phase; its data-phase response is checked after the next edge.
  task automatic xfer(input string tag, input logic [1:0] trans, input logic [31:0] addr,
                      input logic [3:0] size, input logic wr, input bit release_rst = 1'b0);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    htrans    = trans;
    haddr     = addr;
    hsize     = size;
    hwrite    = wr;
    hburst    = 3'($urandom_range(0, 7));
    hport     = 4'($urandom_range(0, 15));
    hmastlock = 1'($urandom_range(0, 1));
    e.tag = tag;
    if (m_err1) begin
      m_err1 = 1'b0;
      e.rdy  = 1'b1;
      e.resp = 1'b1;
    end else if (trans >= 2'd2) begin
      if (exp_legal(addr, size)) begin
        e.rdy  = 1'b1;
        e.resp = 1'b0;
        if (!wr) m_rdata = exp_word(addr);
      end else begin
        m_err1 = 1'b1;
        e.rdy  = 1'b0;
        e.resp = 1'b1;
      end
    end else begin
      e.rdy  = 1'b1;
      e.resp = 1'b0;
    end
    e.dat = m_rdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      got_e = sb.pop_front();
      check({got_e.tag, ".hready"}, {31'd0, hready}, {31'd0, got_e.rdy});
      check({got_e.tag, ".hresp"},  {31'd0, hresp},  {31'd0, got_e.resp});
      check({got_e.tag, ".hrdata"}, hrdata, got_e.dat);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    haddr     = 32'h0;
    hwrite    = 1'b0;
    hsize     = 4'd2;
    hburst    = 3'd0;
    hport     = 4'd0;
    htrans    = 2'd0;
    hmastlock = 1'b0;

    // Reset values appear with no clock edge having occurred yet.
    #2;
    check("reset.hready", {31'd0, hready}, 32'd1);
    check("reset.hresp",  {31'd0, hresp},  32'd0);
    check("reset.hrdata", hrdata, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    xfer("word_rd",     2'd2, 32'h0000_0010, 4'd2, 1'b0);
    xfer("burst0",      2'd2, 32'h0000_0000, 4'd2, 1'b0);
    xfer("burst1",      2'd3, 32'h0000_0004, 4'd2, 1'b0);
    xfer("burst2",      2'd3, 32'h0000_0008, 4'd2, 1'b0);
    xfer("idle0",       2'd0, 32'h0000_0020, 4'd2, 1'b0);
    xfer("busy0",       2'd1, 32'h0000_0024, 4'd2, 1'b0);
    xfer("misalign",    2'd2, 32'h0000_0002, 4'd2, 1'b0);
    xfer("err1_ignore", 2'd2, 32'h0000_0030, 4'd2, 1'b0);
    xfer("after_err",   2'd2, 32'h0000_0014, 4'd2, 1'b0);
    xfer("oor",         2'd2, 32'h0000_0400, 4'd2, 1'b0);
    xfer("oor_e1",      2'd0, 32'h0000_0000, 4'd2, 1'b0);
    xfer("rd0_after",   2'd2, 32'h0000_0000, 4'd2, 1'b0);
    xfer("write8",      2'd2, 32'h0000_0008, 4'd2, 1'b1);
    xfer("read8",       2'd2, 32'h0000_0008, 4'd2, 1'b0);
    xfer("idle1",       2'd0, 32'h0000_0044, 4'd2, 1'b0);
    xfer("idle2",       2'd0, 32'h0000_0048, 4'd2, 1'b0);
    xfer("half_ok",     2'd2, 32'h0000_0006, 4'd1, 1'b0);
    xfer("byte_ok",     2'd2, 32'h0000_0013, 4'd0, 1'b0);
    xfer("last_word",   2'd2, 32'h0000_03FC, 4'd2, 1'b0);
    xfer("half_bad",    2'd2, 32'h0000_0005, 4'd1, 1'b0);
    xfer("half_bad_e1", 2'd3, 32'h0000_0040, 4'd2, 1'b0);
    xfer("size3_bad",   2'd2, 32'h0000_0000, 4'd3, 1'b0);
    xfer("size3_e1",    2'd0, 32'h0000_0000, 4'd2, 1'b0);
    xfer("top_bit_bad", 2'd2, 32'h8000_0000, 4'd2, 1'b0);
    xfer("top_bit_e1",  2'd0, 32'h0000_0000, 4'd2, 1'b0);
    xfer("wr_bad_e2",   2'd2, 32'h0000_0401, 4'd0, 1'b1);
    xfer("wr_bad_e1",   2'd0, 32'h0000_0000, 4'd2, 1'b0);
    xfer("wr_bad_end",  2'd0, 32'h0000_0000, 4'd2, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 255)) << 2;
        1:       a = 32'($urandom_range(0, 1023));
        2:       a = 32'($urandom_range(1024, 4095));
        default: a = 32'($urandom_range(0, 63)) << 2;
      endcase
      xfer($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), a,
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)));
    end
    xfer("rnd_drain", 2'd0, 32'h0, 4'd2, 1'b0);

    // Reset in the middle of an ERROR response aborts it immediately.
    xfer("pre_rst_rd", 2'd2, 32'h0000_0020, 4'd2, 1'b0);
    xfer("rst_err",    2'd2, 32'h0000_0001, 4'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.hready", {31'd0, hready}, 32'd1);
    check("midrst.hresp",  {31'd0, hresp},  32'd0);
    check("midrst.hrdata", hrdata, 32'h0);
    m_err1  = 1'b0;
    m_rdata = 32'h0;
    @(posedge clk);
    #1;
    check("inrst.hrdata", hrdata, 32'h0);
    // First edge after release samples this read as a fresh address phase.
    xfer("post_rst_rd", 2'd2, 32'h0000_000C, 4'd2, 1'b0, 1'b1);
    xfer("post_rst_idle", 2'd0, 32'h0, 4'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_mcu_dummy_sram.md
SWITCH_MCU_DUMMY_SRAM -- requirements
Module: switch_mcu_dummy_sram

Interface
REQ-001 Parameter ADDR_W, default 8: log2 of memory depth in 32-bit words (256 words, 1 KiB).
REQ-002 in_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 in_rst  input  1  reset; asynchronous and active-low.
REQ-004 in_haddr  input  32  AHB address, byte-addressed.
REQ-005 in_hwrite  input  1  1 = write transfer, 0 = read.
REQ-006 in_hsize  input  4  transfer size: 0 byte, 1 halfword, 2 word; all other values illegal.
REQ-007 in_hburst  input  3  burst type; ignored.
REQ-008 in_hport  input  4  protection/port info; ignored.
REQ-009 in_htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
REQ-010 in_hmastlock  input  1  locked transfer; ignored.
REQ-011 out_hready  output  1  transfer done / slave ready.
REQ-012 out_hresp  output  1  0 OKAY, 1 ERROR.
REQ-013 out_hrdata  output  32  read data, valid in the data phase when out_hready=1 and out_hresp=0.

Function
REQ-014 Read-only AHB-Lite slave; no write-data port; array of 2^ADDR_W 32-bit words.
REQ-015 Contents are fixed: word i = {16'hC0DE, 8'h00, i[7:0]}; contents are never modified.
REQ-016 Address phase is sampled at a rising edge when out_hready=1 and in_htrans is NONSEQ or SEQ.
REQ-017 A transfer is legal when all of these hold: in_hsize <= 2; the address is size-aligned (halfword: haddr[0]=0; word: haddr[1:0]=0); and haddr[31:ADDR_W+2] == 0.
REQ-018 Legal read: zero wait states; on the sampling edge, out_hrdata <= word[haddr[ADDR_W+1:2]] (full word regardless of size); out_hready=1 and out_hresp=0 in the following cycle.
REQ-019 Legal write: completes OKAY with zero wait states; memory and out_hrdata are unchanged.
REQ-020 Illegal transfer: two-cycle ERROR response.
- Cycle 1: out_hready=0, out_hresp=1.
- Cycle 2: out_hready=1, out_hresp=1.
- out_hrdata holds its previous value throughout.
REQ-021 The address phase presented during ERROR cycle 1 is not sampled. The address phase presented during ERROR cycle 2 is sampled normally.
REQ-022 IDLE/BUSY, or htrans sampled while out_hready=0: OKAY, zero wait; out_hrdata holds.
REQ-023 Back-to-back legal transfers sustain one transfer per cycle.
REQ-024 Implementation uses a 2-state response FSM.
- States: OKAY and ERR1.
- ERR1 is entered on an illegal sampled transfer and returns to OKAY after one cycle.
- ERR1 drives hready=0 and hresp=1.
- An hresp_q flag produces hresp=1 in the cycle following ERR1.

Reset
REQ-025 While in_rst=0: out_hready=1, out_hresp=0, out_hrdata=32'h0, FSM in OKAY; this takes effect immediately, without a clock edge.
REQ-026 Reset asserted mid-transfer (including during an ERROR response) aborts that transfer; the first edge after release samples a fresh address phase.

Verification
REQ-027 Reset check: in_rst=0 -> out_hready=1, out_hresp=0, out_hrdata=0, with no clock edge.
REQ-028 Word read: NONSEQ read, haddr=0x0000_0010, hsize=2 -> next cycle out_hrdata=0xC0DE_0004, hready=1, hresp=0.
REQ-029 Burst read: SEQ reads at 0x0, 0x4, 0x8 on consecutive cycles -> data 0xC0DE_0000, 0xC0DE_0001, 0xC0DE_0002 in successive cycles, hready constantly 1.
REQ-030 Misaligned read: haddr=0x0000_0002, hsize=2 -> hready=0/hresp=1, then hready=1/hresp=1; out_hrdata unchanged.
REQ-031 Out-of-range access: haddr=0x0000_0400 -> two-cycle ERROR; a following read at 0x0 after the error completes OKAY with data 0xC0DE_0000.
REQ-032 Write then read: write at 0x8 -> OKAY; a subsequent read at 0x8 -> 0xC0DE_0002. IDLE cycles -> hrdata holds.
